instruction_mem: RTL and testbench
==================================

INSTRUCTION_MEM -- requirements
Module: instruction_mem

Interface
REQ-001 Parameter: DEPTH, default 256, number of 32-bit instruction words; power of two, 4..4096.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: instruction_address  input  32  word index of the instruction to fetch; 0,1,2,... are consecutive instructions.
REQ-005 Port: instruction  output  32  instruction word at instruction_address.
REQ-006 Port: addr_oob  output  1  high when instruction_address >= DEPTH.
REQ-007 Port: prog_we  input  1  program-load write enable.
REQ-008 Port: prog_addr  input  32  word index for program-load write.
REQ-009 Port: prog_data  input  32  word written on program load.
REQ-010 Port: prog_err  output  1  registered; high for one cycle after a rejected write.

Function
REQ-011 Storage SHALL be a DEPTH x 32-bit word array.
REQ-012 Read SHALL be combinational, with zero-cycle latency: instruction follows instruction_address with no clock edge required.
REQ-013 For instruction_address >= DEPTH, instruction SHALL be 0x00000013 (NOP) and addr_oob SHALL be 1; otherwise addr_oob SHALL be 0.
REQ-014 The upper address bits SHALL NOT alias: any set bit at or above log2(DEPTH) counts as out of range.
REQ-015 When prog_we=1, rst_n=1 and prog_addr < DEPTH, prog_data SHALL be written to word prog_addr at the rising edge.
REQ-016 A write with prog_addr >= DEPTH SHALL be discarded, with prog_err=1 on the following cycle. Otherwise prog_err SHALL be 0.
REQ-017 A simultaneous write and read of the same word SHALL return the old value before the edge and the new value combinationally after it; there is no bypass.
REQ-018 Only one write SHALL occur per cycle; there is no handshake.

Reset
REQ-019 When rst_n=0 at a rising edge, the array SHALL be reloaded with the default program: word0=0x00500093 (addi x1,x0,5), word1=0x00A00113 (addi x2,x0,10), word2=0x002081B3 (add x3,x1,x2), word3=0x40110233 (sub x4,x2,x1), all other words=0x00000013.
REQ-020 Reset SHALL take priority over prog_we; writes in a reset cycle are ignored.
REQ-021 After reset, prog_err SHALL be 0.
REQ-022 Reset asserted mid-program-load SHALL discard all loaded words.
REQ-023 The same default contents SHALL be present at time zero (initial load), so reads are valid before the first reset edge.
REQ-024 Reads SHALL remain combinational while rst_n=0, and SHALL reflect the array contents.

Verification
REQ-025 Bench SHALL cover the following scenarios:
- Time zero, no clock: address 0,1,2,3, each held 10 time units -> instruction 0x00500093, 0x00A00113, 0x002081B3, 0x40110233; addr_oob=0.
- Address 4 and DEPTH-1 -> 0x00000013; address DEPTH and 0xFFFFFFFF -> 0x00000013 with addr_oob=1.
- Write prog_addr=2, prog_data=0xDEADBEEF, with instruction_address=2 -> 0x002081B3 before the edge, 0xDEADBEEF after it; prog_err stays 0.
- Write prog_addr=DEPTH, prog_data=0x12345678 -> prog_err=1 for exactly one cycle; a read of address 0 is unchanged at 0x00500093.
- After writing 0xCAFEF00D to word 1, one cycle of rst_n=0 with prog_we=1, prog_addr=0 -> word1 reads 0x00A00113 and word0 reads 0x00500093 (write ignored).
- Back-to-back writes to words 10..13, then read back -> each value returned, and neighbouring words 9 and 14 still read 0x00000013.

Source files
------------

// File: rtl/instruction_mem.sv
// Instruction store with combinational fetch, program-load write port and a
// synchronous reset that reloads a small default program.
module instruction_mem #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction_address,
  output logic [31:0] instruction,
  output logic        addr_oob,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data,
  output logic        prog_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] WORD0 = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] WORD1 = 32'h00A0_0113;  // addi x2,x0,10
  localparam logic [31:0] WORD2 = 32'h0020_81B3;  // add  x3,x1,x2
  localparam logic [31:0] WORD3 = 32'h4011_0233;  // sub  x4,x2,x1

  function automatic logic [31:0] default_word(input int idx);
    case (idx)
      0:       default_word = WORD0;
      1:       default_word = WORD1;
      2:       default_word = WORD2;
      3:       default_word = WORD3;
      default: default_word = NOP;
    endcase
  endfunction

  // NOTE: the whole array is reloaded on reset, so it maps to flops rather
  // than a RAM macro; the declaration initializer supplies the same image at
  // power-up so fetches are valid before the first reset edge.
  logic [31:0] mem [DEPTH] = '{0: WORD0, 1: WORD1, 2: WORD2, 3: WORD3, default: NOP};

  logic rd_oob;
  logic wr_oob;

  // Any set bit above the index field is out of range; addresses never alias.
  assign rd_oob = |instruction_address[31:AW];
  assign wr_oob = |prog_addr[31:AW];

  always_comb begin
    addr_oob    = rd_oob;
    instruction = rd_oob ? NOP : mem[instruction_address[AW-1:0]];
  end

  // NOTE: sequential state uses non-blocking assignments so every reader sees
  // pre-edge values; a same-word read returns the old word until the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= default_word(i);
      prog_err <= 1'b0;
    end else begin
      if (prog_we && !wr_oob) mem[prog_addr[AW-1:0]] <= prog_data;
      prog_err <= prog_we && wr_oob;
    end
  end

endmodule

// File: tb/tb_instruction_mem.sv
// Self-checking bench for instruction_mem: directed vectors plus a per-cycle
// comparison against an array-based reference model.
module tb_instruction_mem;

  localparam int DEPTH = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst_n;
  logic [31:0] instruction_address;
  logic [31:0] instruction;
  logic        addr_oob;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        prog_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic        model_err = 1'b0;
  bit          compare_en = 1'b0;

  instruction_mem #(.DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .instruction_address (instruction_address),
    .instruction         (instruction),
    .addr_oob            (addr_oob),
    .prog_we             (prog_we),
    .prog_addr           (prog_addr),
    .prog_data           (prog_data),
    .prog_err            (prog_err)
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_default_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
    model_mem[0] = 32'h0050_0093;
    model_mem[1] = 32'h00A0_0113;
    model_mem[2] = 32'h0020_81B3;
    model_mem[3] = 32'h4011_0233;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a >= DEPTH) return NOP;
    return model_mem[a];
  endfunction

  // Reference model: one word per cycle, reset wins, out-of-range flagged.
  always @(posedge clk) begin
    if (!rst_n) begin
      load_default_model();
      model_err = 1'b0;
    end else begin
      if (prog_we && prog_addr < DEPTH) model_mem[prog_addr] = prog_data;
      model_err = prog_we && (prog_addr >= DEPTH);
    end
  end

  always @(negedge clk) begin
    if (compare_en) begin
      check("cmp_instruction", instruction, model_read(instruction_address));
      check("cmp_addr_oob", {31'd0, addr_oob}, {31'd0, instruction_address >= DEPTH});
      check("cmp_prog_err", {31'd0, prog_err}, {31'd0, model_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic read_lit(input string name, input logic [31:0] a,
                          input logic [31:0] exp, input logic exp_oob);
    instruction_address = a;
    #1;
    check(name, instruction, exp);
    check({name, "_oob"}, {31'd0, addr_oob}, {31'd0, exp_oob});
  endtask

  initial begin
    logic [31:0] tz_exp [4];
    tz_exp[0] = 32'h0050_0093;
    tz_exp[1] = 32'h00A0_0113;
    tz_exp[2] = 32'h0020_81B3;
    tz_exp[3] = 32'h4011_0233;
    load_default_model();
    rst_n = 1'b1;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    instruction_address = '0;

    // Power-up image, no clock running, each address held 10 time units.
    for (int i = 0; i < 4; i++) begin
      instruction_address = i;
      #5;
      check("tz_instruction", instruction, tz_exp[i]);
      check("tz_addr_oob", {31'd0, addr_oob}, 32'd0);
      #5;
    end

    clk_run = 1'b1;
    #2;
    compare_en = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("reset_prog_err", {31'd0, prog_err}, 32'd0);

    read_lit("rd_addr4", 32'd4, NOP, 1'b0);
    read_lit("rd_last", DEPTH - 1, NOP, 1'b0);
    read_lit("rd_depth", DEPTH, NOP, 1'b1);
    read_lit("rd_all_ones", 32'hFFFF_FFFF, NOP, 1'b1);
    read_lit("rd_high_bit", 32'h8000_0000, NOP, 1'b1);

    // Same-word write and read: old value before the edge, new after.
    instruction_address = 32'd2;
    prog_we = 1'b1; prog_addr = 32'd2; prog_data = 32'hDEAD_BEEF;
    #1;
    check("wr2_before", instruction, 32'h0020_81B3);
    tick();
    prog_we = 1'b0;
    check("wr2_after", instruction, 32'hDEAD_BEEF);
    check("wr2_prog_err", {31'd0, prog_err}, 32'd0);

    // Rejected write: one-cycle error pulse, contents untouched.
    prog_we = 1'b1; prog_addr = DEPTH; prog_data = 32'h1234_5678;
    tick();
    prog_we = 1'b0;
    check("oob_err_set", {31'd0, prog_err}, 32'd1);
    read_lit("oob_word0", 32'd0, 32'h0050_0093, 1'b0);
    tick();
    check("oob_err_clear", {31'd0, prog_err}, 32'd0);

    // Reset mid-load discards loaded words and ignores a concurrent write.
    prog_we = 1'b1; prog_addr = 32'd1; prog_data = 32'hCAFE_F00D;
    tick();
    read_lit("cafe_loaded", 32'd1, 32'hCAFE_F00D, 1'b0);
    prog_addr = DEPTH + 5;
    tick();
    check("err_before_reset", {31'd0, prog_err}, 32'd1);
    rst_n = 1'b0; prog_we = 1'b1; prog_addr = 32'd0; prog_data = 32'h5555_AAAA;
    tick();
    rst_n = 1'b1; prog_we = 1'b0;
    check("rst_prog_err", {31'd0, prog_err}, 32'd0);
    read_lit("rst_word1", 32'd1, 32'h00A0_0113, 1'b0);
    read_lit("rst_word0", 32'd0, 32'h0050_0093, 1'b0);
    read_lit("rst_word2", 32'd2, 32'h0020_81B3, 1'b0);

    // Back-to-back writes to words 10..13, then read back with neighbours.
    for (int i = 0; i < 4; i++) begin
      prog_we = 1'b1; prog_addr = 10 + i; prog_data = 32'hA5A5_0000 + i;
      tick();
    end
    prog_we = 1'b0;
    for (int i = 0; i < 4; i++)
      read_lit("b2b_word", 10 + i, 32'hA5A5_0000 + i, 1'b0);
    read_lit("b2b_word9", 32'd9, NOP, 1'b0);
    read_lit("b2b_word14", 32'd14, NOP, 1'b0);

    // Sweep a few addresses through the per-cycle compare.
    for (int i = 0; i < 20; i++) begin
      instruction_address = (i == 19) ? 32'h0000_0100 : i;
      tick();
    end

    compare_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
